// File: rtl/hdmi_packet_pkg.sv
// rtl/hdmi_packet_pkg.sv - shared packet constants, sample types and selection codes
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL         = 8'h00;
  localparam logic [7:0] PKT_ACR          = 8'h01;
  localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;

  localparam int IEC_FRAMES_PER_BLOCK = 192;

  typedef enum logic {
    LAYOUT_2CH = 1'b0,
    LAYOUT_8CH = 1'b1
  } audio_layout_t;

  typedef logic [23:0] sample24_t;

  typedef enum logic [2:0] {
    SEL_NULL,
    SEL_ACR,
    SEL_AUDIO,
    SEL_FORCE,
    SEL_DUE
  } sel_t;

  // Narrow samples sit in the top bits with zero LSBs.
  function automatic sample24_t justify_sample(input sample24_t s, input int width);
    return s << (24 - width);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - circular sample-frame buffer, single push, multi-entry pop
module audio_sample_fifo #(
  parameter int WIDTH   = 48,
  parameter int DEPTH   = 8,
  parameter int MAX_POP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic [2:0]               pop_n,
  output logic [MAX_POP*WIDTH-1:0] head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;

  always_comb begin
    head = '0;
    for (int i = 0; i < MAX_POP; i++) begin
      head[i*WIDTH +: WIDTH] = mem[rd_ptr + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets both pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + (AW+1)'(push_ok) - (AW+1)'(pop_n);
    end
  end

endmodule

// File: rtl/packet_scheduler.sv
// rtl/packet_scheduler.sv - data-island packet arbiter with audio sample packing
// Optional statistics outputs are built when PACKET_SCHEDULER_STATS_EN is defined.
module packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int         AUDIO_BIT_WIDTH        = 24,
  parameter int         AUDIO_CHANNELS         = 2,
  parameter int         MAX_SAMPLES_PER_PACKET = 4,
  parameter int         FIFO_DEPTH             = 8,
  parameter int         NUM_INFOFRAMES         = 3,
  parameter logic [7:0] INFOFRAME_TYPES [NUM_INFOFRAMES] = '{8'h84, 8'h82, 8'h83},
  parameter int         INFOFRAME_PERIOD       = 2
) (
  input  logic                                      clk_pixel,
  input  logic                                      reset_n,
  input  logic                                      video_field_end,
  input  logic                                      packet_enable,
  input  logic                                      sample_valid,
  output logic                                      sample_ready,
  input  logic [AUDIO_CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_word,
  input  logic                                      acr_request,
  input  logic [NUM_INFOFRAMES-1:0]                 infoframe_force,
  output logic [7:0]                                packet_type,
  output logic                                      packet_valid,
  output logic                                      audio_layout,
  output logic [191:0]                              audio_sample_word_packet,
  output logic [3:0]                                audio_sample_word_present,
  output logic [7:0]                                frame_counter
`ifdef PACKET_SCHEDULER_STATS_EN
  ,
  output logic [15:0]                               null_count,
  output logic [15:0]                               acr_coalesced_count
`endif
);

  localparam int MAXS = (AUDIO_CHANNELS == 8) ? 1 : MAX_SAMPLES_PER_PACKET;
  localparam int W    = AUDIO_BIT_WIDTH;
  localparam int FW   = AUDIO_CHANNELS * AUDIO_BIT_WIDTH;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam audio_layout_t LAYOUT = (AUDIO_CHANNELS == 8) ? LAYOUT_8CH : LAYOUT_2CH;

  logic [MAXS*FW-1:0]        head;
  logic [CW-1:0]             count;
  logic                      full;
  logic                      empty;
  logic [2:0]                n;
  logic [2:0]                pop_n;
  logic                      push;

  logic [3:0]                field_cnt;
  logic                      field_wrap;
  logic                      acr_pending;
  logic                      last_audio;
  logic [NUM_INFOFRAMES-1:0] force_q;
  logic [NUM_INFOFRAMES-1:0] sent;
  logic [NUM_INFOFRAMES-1:0] sent_eff;
  logic [NUM_INFOFRAMES-1:0] slot_mask;
  logic [7:0]                next_frame;
  logic [7:0]                frame_after;
  logic [8:0]                sum9;

  sel_t                      sel;
  logic [7:0]                if_type;
  logic [7:0]                type_next;
  logic                      acr_take;
  logic                      slot_take;
  logic [191:0]              pay_next;
  logic [3:0]                pres_next;

  assign sample_ready = !full;
  assign push         = sample_valid && !full;
  assign audio_layout = LAYOUT;

  audio_sample_fifo #(
    .WIDTH   (FW),
    .DEPTH   (FIFO_DEPTH),
    .MAX_POP (MAXS)
  ) u_fifo (
    .clk       (clk_pixel),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (sample_word),
    .pop_n     (pop_n),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign field_wrap = video_field_end && (field_cnt == 4'(INFOFRAME_PERIOD - 1));
  assign n          = (count > CW'(MAXS)) ? 3'(MAXS) : 3'(count);

  always_comb begin
    // A field wrap coinciding with a selection clears sent flags first.
    sent_eff  = field_wrap ? '0 : sent;
    sel       = SEL_NULL;
    if_type   = PKT_NULL;
    slot_mask = '0;
    if (acr_pending && last_audio) sel = SEL_ACR;
    else if (!empty)               sel = SEL_AUDIO;
    else if (acr_pending)          sel = SEL_ACR;
    else if (|force_q)             sel = SEL_FORCE;
    else if (!(&sent_eff))         sel = SEL_DUE;
    for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
      if ((sel == SEL_FORCE && force_q[i]) || (sel == SEL_DUE && !sent_eff[i])) begin
        if_type   = INFOFRAME_TYPES[i];
        slot_mask = NUM_INFOFRAMES'(1) << i;
      end
    end
    case (sel)
      SEL_AUDIO:          type_next = PKT_AUDIO_SAMPLE;
      SEL_ACR:            type_next = PKT_ACR;
      SEL_FORCE, SEL_DUE: type_next = if_type;
      default:            type_next = PKT_NULL;
    endcase
  end

  assign acr_take  = packet_enable && (sel == SEL_ACR);
  assign slot_take = packet_enable && (sel == SEL_FORCE || sel == SEL_DUE);
  assign pop_n     = (packet_enable && sel == SEL_AUDIO) ? n : 3'd0;

  assign sum9        = {1'b0, next_frame} + {6'b0, n};
  assign frame_after = (sum9 >= 9'(IEC_FRAMES_PER_BLOCK)) ? 8'(sum9 - 9'(IEC_FRAMES_PER_BLOCK))
                                                          : sum9[7:0];

  generate
    if (AUDIO_CHANNELS == 8) begin : g_layout1
      assign pres_next = 4'b1111;
      always_comb begin
        pay_next = '0;
        for (int k = 0; k < 8; k++) begin
          pay_next[k*24 +: 24] = justify_sample(24'(head[k*W +: W]), W);
        end
      end
    end else begin : g_layout0
      always_comb begin
        pay_next  = '0;
        pres_next = '0;
        for (int k = 0; k < MAXS; k++) begin
          if (3'(k) < n) begin
            pres_next[k] = 1'b1;
            for (int c = 0; c < 2; c++) begin
              pay_next[k*48 + c*24 +: 24] = justify_sample(24'(head[k*FW + c*W +: W]), W);
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      packet_type               <= PKT_NULL;
      packet_valid              <= 1'b0;
      audio_sample_word_present <= '0;
      audio_sample_word_packet  <= '0;
      frame_counter             <= '0;
      next_frame                <= '0;
      acr_pending               <= 1'b0;
      last_audio                <= 1'b0;
      force_q                   <= '0;
      sent                      <= '0;
      field_cnt                 <= '0;
    end else begin
      if (video_field_end) field_cnt <= field_wrap ? 4'd0 : field_cnt + 4'd1;
      acr_pending <= (acr_pending && !acr_take) || acr_request;
      force_q     <= (force_q & ~((slot_take && sel == SEL_FORCE) ? slot_mask : '0)) | infoframe_force;
      sent        <= sent_eff | (slot_take ? slot_mask : '0);
      if (packet_enable) begin
        packet_valid <= 1'b1;
        last_audio   <= (sel == SEL_AUDIO);
        packet_type  <= type_next;
        if (sel == SEL_AUDIO) begin
          audio_sample_word_present <= pres_next;
          audio_sample_word_packet  <= pay_next;
          frame_counter             <= next_frame;
          next_frame                <= frame_after;
        end else begin
          audio_sample_word_present <= '0;
          audio_sample_word_packet  <= '0;
        end
      end
    end
  end

`ifdef PACKET_SCHEDULER_STATS_EN
  logic [15:0] null_acc;
  logic [15:0] coal_acc;

  // Per-field accumulators; the finished field's totals move to the outputs.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      null_acc            <= '0;
      coal_acc            <= '0;
      null_count          <= '0;
      acr_coalesced_count <= '0;
    end else if (video_field_end) begin
      null_count          <= null_acc;
      acr_coalesced_count <= coal_acc;
      null_acc            <= '0;
      coal_acc            <= '0;
    end else begin
      if (packet_enable && sel == SEL_NULL && null_acc != 16'hFFFF) null_acc <= null_acc + 16'd1;
      if (acr_request && acr_pending && !acr_take && coal_acc != 16'hFFFF) coal_acc <= coal_acc + 16'd1;
    end
  end
`endif

endmodule
